wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
Writer-side counterpart to the decode stage. It accepts completed results from the MEM stage and formats load data (word or LB byte). It drives the register-file write port. It keeps a per-register pending-write scoreboard that produces the has_hazard signal consumed by decode. Decode marks destinations at issue; this block clears them at commit.

Parameters:
NREG, 32, number of architectural registers (register 0 hard-wired zero)
CNT_W, 2, width of per-register pending-write counter (max 2^CNT_W-1 in flight)

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
issue_valid  input  1  decode issuing an instruction this cycle (not stalled)
issue_reg_write  input  1  issued instruction writes a register
issue_rd  input  5  destination of issued instruction
src1  input  5  decode source 1 (rs)
src1_valid  input  1  src1 actually read
src2  input  5  decode source 2 (rt)
src2_valid  input  1  src2 actually read
has_hazard  output  1  decode must stall (combinational)
wb_valid  input  1  MEM stage presents a result
wb_reg_write  input  1  result writes a register
wb_rd  input  5  destination register
wb_mem_to_reg  input  1  1: take mem_data, 0: take alu_result
wb_is_LB  input  1  byte load
wb_byte_sel  input  2  byte lane for LB (0 = bits 7:0)
alu_result  input  32  ALU result
mem_data  input  32  cache/memory read word
rd_we  output  1  register-file write enable (registered)
rd_addr  output  5  register-file write address (registered)
rd_data  output  32  register-file write data (registered)
drained  output  1  no pending writes anywhere
sb_error  output  1  sticky: commit to register with zero pending count

Behaviour:
- Reset (async, rst_b low): all counters 0; rd_we=0; rd_addr=0; rd_data=0; sb_error=0. drained=1 and has_hazard=0 follow combinationally.
- Commit pipeline, 1-cycle latency. When wb_valid && wb_reg_write && wb_rd!=0 at edge N, rd_we=1 during cycle N+1 with rd_addr=wb_rd. Otherwise rd_we=0 next cycle; rd_addr/rd_data hold.
- Data select: wb_mem_to_reg=0 gives alu_result. Otherwise wb_is_LB=0 gives mem_data. LB gives mem_data[8*sel+7:8*sel], sign-extended to 32.
- Counter update at each edge: inc = issue_valid && issue_reg_write && issue_rd!=0; dec = rd_we && rd_addr!=0.
  - Same register inc and dec: net unchanged.
  - Decrement applies on the same edge the register file captures the write, so reads after that edge see new data.
- Saturation: a counter at max is never incremented. Decode is stalled by has_hazard before this can happen.
- Underflow: dec on a zero counter leaves it at 0 and sets sb_error (sticky until reset).
- has_hazard is 1 if any of these holds:
  - src1_valid and src1!=0 and cnt[src1]!=0
  - src2_valid and src2!=0 and cnt[src2]!=0
  - issue_reg_write and issue_rd!=0 and cnt[issue_rd]==max
- has_hazard depends only on current counters and decode inputs, not on issue_valid. This avoids a combinational loop through decode's stall logic.
- drained = all counters zero.
- Register 0 is never marked or hazardous.
- rst_b asserted mid-operation discards in-flight commit and all counts immediately.

Optional Feature:
SB_BYPASS_EN.
- Defined: a source is not hazardous when its counter is exactly 1 and rd_we && rd_addr==src this cycle. Outputs fwd1_en, fwd2_en (1 bit each) and fwd_data (=rd_data) are added so decode can take the committing value.
- Undefined: those ports are absent; hazard holds until the counter edge clears, costing one extra stall cycle per RAW dependency.

Decomposition:
- Shared package wb_pkg:
  - NREG, CNT_W, REG_ZERO constants
  - typedef reg_idx_t (logic [4:0])
  - typedef sb_cnt_t (logic [CNT_W-1:0])
  - function lb_extract(word, sel) returning the sign-extended byte
- One sub-module sb_counter_array holds the counter array with inc/dec/underflow logic, read ports for src1/src2/issue_rd, and the drained output. The top module holds data formatting, the commit register, and hazard/bypass logic.

Test Plan:
1. Reset, then issue add to r5 (issue_valid=1, rd=5); next cycle src1=5 valid -> has_hazard=1. Drive wb_valid for r5 with alu_result=0x1234 -> rd_we=1, rd_addr=5, rd_data=0x00001234 one cycle later; has_hazard=0 the cycle after that.
2. LB: mem_data=0x80FF7F01, wb_mem_to_reg=1, wb_is_LB=1.
   - sel=0 -> rd_data=0x00000001
   - sel=2 -> rd_data=0xFFFFFFFF
   - sel=3 -> rd_data=0xFFFFFF80
3. Issue to r0 plus src1=0 valid -> has_hazard=0, counters unchanged, drained stays 1; wb to r0 -> rd_we stays 0.
4. Issue r7 three times without commit -> cnt=3. Fourth issue to r7 -> has_hazard=1 and count remains 3. Same-cycle issue r7 with commit r7 -> count unchanged.
5. Commit to r9 with zero count -> sb_error=1, which stays 1 until rst_b pulse. Async reset mid-commit clears rd_we within the same cycle.
6. With SB_BYPASS_EN: count[r4]=1, rd_we to r4 with data 0xAA, src2=4 valid -> has_hazard=0, fwd2_en=1, fwd_data=0xAA. Without the macro, has_hazard=1 that cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types, sizes and the load-byte formatter for the writeback scoreboard.
package wb_pkg;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam sb_cnt_t  CNT_MAX  = '1;

  function automatic logic [31:0] lb_extract(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {{24{b[7]}}, b};
  endfunction
endpackage

// File: rtl/wb_scoreboard_sb_counter_array.sv
// Per-register pending-write counters with saturating increment, guarded
// decrement, sticky underflow flag and three read ports.
module sb_counter_array
  import wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_b,
  input  logic     inc_en,
  input  reg_idx_t inc_idx,
  input  logic     dec_en,
  input  reg_idx_t dec_idx,
  input  reg_idx_t rd1_idx,
  input  reg_idx_t rd2_idx,
  input  reg_idx_t rd3_idx,
  output sb_cnt_t  rd1_cnt,
  output sb_cnt_t  rd2_cnt,
  output sb_cnt_t  rd3_cnt,
  output logic     drained,
  output logic     sb_error
);
  sb_cnt_t          cnt_w [NREG];
  logic [NREG-1:0]  nz_w;
  logic             sb_error_q, sb_error_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_w[gi] = '0;
      end else begin : g_reg
        sb_cnt_t cnt_q, cnt_d;
        logic    inc_hit, dec_hit;
        assign inc_hit = inc_en && (inc_idx == reg_idx_t'(gi));
        assign dec_hit = dec_en && (dec_idx == reg_idx_t'(gi));
        // A matching inc/dec pair cancels; otherwise clamp at 0 and at max.
        always_comb begin
          cnt_d = cnt_q;
          if (dec_hit && !inc_hit) begin
            if (cnt_q != '0) cnt_d = cnt_q - sb_cnt_t'(1);
          end else if (inc_hit && !dec_hit) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + sb_cnt_t'(1);
          end
        end
        always_ff @(posedge clk or negedge rst_b) begin
          if (!rst_b) cnt_q <= '0;
          else        cnt_q <= cnt_d;
        end
        assign cnt_w[gi] = cnt_q;
      end
      assign nz_w[gi] = |cnt_w[gi];
    end
  endgenerate

  assign sb_error_d = sb_error_q ||
                      (dec_en && (dec_idx != REG_ZERO) && (cnt_w[dec_idx] == '0));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sb_error_q <= 1'b0;
    else        sb_error_q <= sb_error_d;
  end

  assign rd1_cnt  = cnt_w[rd1_idx];
  assign rd2_cnt  = cnt_w[rd2_idx];
  assign rd3_cnt  = cnt_w[rd3_idx];
  assign drained  = ~|nz_w;
  assign sb_error = sb_error_q;
endmodule

// File: rtl/wb_scoreboard.sv
// Writeback stage: formats results, drives the register-file write port and
// reports RAW/WAW-overflow hazards to decode. Optional SB_BYPASS_EN adds forwarding.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        issue_valid,
  input  logic        issue_reg_write,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  src1,
  input  logic        src1_valid,
  input  logic [4:0]  src2,
  input  logic        src2_valid,
  output logic        has_hazard,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_mem_to_reg,
  input  logic        wb_is_LB,
  input  logic [1:0]  wb_byte_sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_data,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        drained,
  output logic        sb_error
`ifdef SB_BYPASS_EN
  ,
  output logic        fwd1_en,
  output logic        fwd2_en,
  output logic [31:0] fwd_data
`endif
);
  logic        rd_we_q;
  reg_idx_t    rd_addr_q;
  logic [31:0] rd_data_q, wb_data_d;
  logic        wb_fire, inc_en, dec_en;
  sb_cnt_t     cnt1, cnt2, cnt_iss;
  logic        busy1, busy2, byp1, byp2, full_iss;

  assign wb_fire = wb_valid && wb_reg_write && (wb_rd != REG_ZERO);
  assign inc_en  = issue_valid && issue_reg_write && (issue_rd != REG_ZERO);
  assign dec_en  = rd_we_q && (rd_addr_q != REG_ZERO);

  always_comb begin
    wb_data_d = alu_result;
    if (wb_mem_to_reg) wb_data_d = wb_is_LB ? lb_extract(mem_data, wb_byte_sel) : mem_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_we_q <= wb_fire;
      if (wb_fire) begin
        rd_addr_q <= wb_rd;
        rd_data_q <= wb_data_d;
      end
    end
  end

  sb_counter_array u_cnt (
    .clk     (clk),
    .rst_b   (rst_b),
    .inc_en  (inc_en),
    .inc_idx (issue_rd),
    .dec_en  (dec_en),
    .dec_idx (rd_addr_q),
    .rd1_idx (src1),
    .rd2_idx (src2),
    .rd3_idx (issue_rd),
    .rd1_cnt (cnt1),
    .rd2_cnt (cnt2),
    .rd3_cnt (cnt_iss),
    .drained (drained),
    .sb_error(sb_error)
  );

  // Gated on issue_reg_write rather than issue_valid so stall logic stays loop-free.
  assign busy1    = src1_valid && (src1 != REG_ZERO) && (cnt1 != '0);
  assign busy2    = src2_valid && (src2 != REG_ZERO) && (cnt2 != '0);
  assign full_iss = issue_reg_write && (issue_rd != REG_ZERO) && (cnt_iss == CNT_MAX);

`ifdef SB_BYPASS_EN
  assign byp1     = (cnt1 == sb_cnt_t'(1)) && rd_we_q && (rd_addr_q == src1);
  assign byp2     = (cnt2 == sb_cnt_t'(1)) && rd_we_q && (rd_addr_q == src2);
  assign fwd1_en  = busy1 && byp1;
  assign fwd2_en  = busy2 && byp2;
  assign fwd_data = rd_data_q;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign has_hazard = (busy1 && !byp1) || (busy2 && !byp2) || full_iss;

  assign rd_we   = rd_we_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed plus randomized check of wb_scoreboard against a count-table model.
module tb_wb_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, issue_valid, issue_reg_write, src1_valid, src2_valid;
  logic [4:0] issue_rd, src1, src2, wb_rd, rd_addr;
  logic has_hazard, wb_valid, wb_reg_write, wb_mem_to_reg, wb_is_LB;
  logic [1:0] wb_byte_sel;
  logic [31:0] alu_result, mem_data, rd_data;
  logic rd_we, drained, sb_error;
`ifdef SB_BYPASS_EN
  logic fwd1_en, fwd2_en;
  logic [31:0] fwd_data;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_scoreboard dut (
    .clk(clk), .rst_b(rst_b), .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
    .issue_rd(issue_rd), .src1(src1), .src1_valid(src1_valid), .src2(src2),
    .src2_valid(src2_valid), .has_hazard(has_hazard), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_is_LB(wb_is_LB), .wb_byte_sel(wb_byte_sel), .alu_result(alu_result),
    .mem_data(mem_data), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .drained(drained), .sb_error(sb_error)
`ifdef SB_BYPASS_EN
    , .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd_data(fwd_data)
`endif
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference state: outstanding writes per register and the pending commit.
  int cnt [32];
  bit m_err, m_we;
  bit [4:0] m_addr;
  bit [31:0] m_data;

  function automatic bit [31:0] ref_data();
    int b;
    if (!wb_mem_to_reg) return alu_result;
    if (!wb_is_LB) return mem_data;
    b = (mem_data >> (8 * int'(wb_byte_sel))) & 255;
    if (b >= 128) b = b - 256;
    return b;
  endfunction

  function automatic bit src_haz(input bit v, input int s);
    if (!v || s == 0 || cnt[s] == 0) return 0;
    if (BYP && cnt[s] == 1 && m_we && m_addr == s) return 0;
    return 1;
  endfunction

  function automatic bit ref_haz();
    return src_haz(src1_valid, src1) || src_haz(src2_valid, src2) ||
           (issue_reg_write && issue_rd != 0 && cnt[issue_rd] == 3);
  endfunction

  function automatic bit ref_drained();
    foreach (cnt[i]) if (cnt[i] != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    foreach (cnt[i]) cnt[i] = 0;
    m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit inc, dec, fire;
    inc  = issue_valid && issue_reg_write && issue_rd != 0;
    dec  = m_we && m_addr != 0;
    fire = wb_valid && wb_reg_write && wb_rd != 0;
    if (dec && cnt[m_addr] == 0) m_err = 1;
    if (!(inc && dec && issue_rd == m_addr)) begin
      if (dec && cnt[m_addr] > 0) cnt[m_addr]--;
      if (inc && cnt[issue_rd] < 3) cnt[issue_rd]++;
    end
    if (fire) begin m_addr = wb_rd; m_data = ref_data(); end
    m_we = fire;
  endtask

  task automatic check_all();
    chk("has_hazard", has_hazard, ref_haz());
    chk("drained", drained, ref_drained());
    chk("rd_we", rd_we, m_we);
    chk("rd_addr", rd_addr, m_addr);
    chk("rd_data", rd_data, m_data);
    chk("sb_error", sb_error, m_err);
`ifdef SB_BYPASS_EN
    chk("fwd1_en", fwd1_en, src1_valid && src1 != 0 && cnt[src1] == 1 && m_we && m_addr == src1);
    chk("fwd2_en", fwd2_en, src2_valid && src2 != 0 && cnt[src2] == 1 && m_we && m_addr == src2);
    chk("fwd_data", fwd_data, m_data);
`endif
  endtask

  task automatic cycle();
    @(negedge clk); check_all();
    @(posedge clk); model_step();
    #1;
  endtask

  task automatic clr_in();
    issue_valid = 0; issue_reg_write = 0; issue_rd = 0; src1 = 0; src1_valid = 0;
    src2 = 0; src2_valid = 0; wb_valid = 0; wb_reg_write = 0; wb_rd = 0;
    wb_mem_to_reg = 0; wb_is_LB = 0; wb_byte_sel = 0; alu_result = 0; mem_data = 0;
  endtask

  task automatic issue(input int rd);
    issue_valid = 1; issue_reg_write = 1; issue_rd = 5'(rd);
  endtask

  task automatic commit_alu(input int rd, input logic [31:0] d);
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5'(rd); wb_mem_to_reg = 0; alu_result = d;
  endtask

  // Called just after a rising edge; reset lands mid-cycle.
  task automatic async_reset(input string tag);
    clr_in();
    rst_b = 0; #1;
    model_reset();
    chk({tag, "_rd_we"}, rd_we, 0);
    check_all();
    #1 rst_b = 1;
  endtask

  initial begin
    clr_in();
    rst_b = 0;
    model_reset();
    #12;
    check_all();
    chk("rst_drained", drained, 1);
    rst_b = 1;
    @(posedge clk); #1;

    // Basic RAW on r5 then commit.
    issue(5); cycle();
    clr_in(); src1 = 5; src1_valid = 1; #1;
    chk("t1_haz", has_hazard, 1);
    commit_alu(5, 32'h1234); cycle();
    chk("t1_we", rd_we, 1); chk("t1_addr", rd_addr, 5); chk("t1_data", rd_data, 32'h0000_1234);
    wb_valid = 0; #1;
    chk("t1_haz_commit", has_hazard, BYP ? 0 : 1);
    cycle();
    chk("t1_haz_clear", has_hazard, 0);
    cycle();

    // Load-byte formatting.
    begin
      logic [1:0] sels [3] = '{2'd0, 2'd2, 2'd3};
      logic [31:0] exps [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FF80};
      for (int i = 0; i < 3; i++) begin
        clr_in();
        wb_valid = 1; wb_reg_write = 1; wb_rd = 5'd3; wb_mem_to_reg = 1; wb_is_LB = 1;
        mem_data = 32'h80FF_7F01; wb_byte_sel = sels[i];
        cycle();
        chk("lb_data", rd_data, exps[i]);
      end
      clr_in(); cycle();
      async_reset("lb_rst");  // those commits had no issue; discard the error
      cycle();
    end

    // Register 0 is never tracked.
    issue(0); src1 = 0; src1_valid = 1; #1;
    chk("r0_haz", has_hazard, 0);
    cycle();
    chk("r0_drained", drained, 1);
    clr_in(); commit_alu(0, 32'hDEAD); cycle();
    chk("r0_we", rd_we, 0);
    clr_in(); cycle();

    // Saturation on r7 and same-cycle inc/dec.
    for (int i = 0; i < 3; i++) begin issue(7); cycle(); end
    issue(7); #1;
    chk("sat_haz", has_hazard, 1);
    cycle();
    clr_in(); commit_alu(7, 32'h77); cycle();
    clr_in(); issue(7); cycle();
    clr_in(); src1 = 7; src1_valid = 1; issue_reg_write = 1; issue_rd = 7; #1;
    chk("sat_still_full", has_hazard, 1);
    cycle();
    clr_in(); cycle();

    // Underflow, sticky error, reset during a commit.
    async_reset("pre_uf");
    cycle();
    commit_alu(9, 32'h9); cycle();
    clr_in(); cycle(); cycle();
    chk("uf_err", sb_error, 1);
    cycle();
    chk("uf_sticky", sb_error, 1);
    commit_alu(10, 32'hA); cycle();
    chk("mid_we", rd_we, 1);
    async_reset("mid");
    chk("mid_err", sb_error, 0);
    cycle();

    // Bypass window on r4.
    issue(4); cycle();
    clr_in(); commit_alu(4, 32'hAA); cycle();
    clr_in(); src2 = 4; src2_valid = 1; #1;
    chk("byp_haz", has_hazard, BYP ? 0 : 1);
`ifdef SB_BYPASS_EN
    chk("byp_fwd2", fwd2_en, 1);
    chk("byp_data", fwd_data, 32'hAA);
`endif
    cycle();
    clr_in(); cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int pend [$];
      if (c % 150 == 149) begin async_reset("rnd_rst"); cycle(); continue; end
      foreach (cnt[i]) if (cnt[i] > 0) pend.push_back(i);
      issue_valid = 1'($urandom_range(0, 1));
      issue_reg_write = ($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom_range(0, 7));
      src1 = 5'($urandom_range(0, 7)); src1_valid = 1'($urandom_range(0, 1));
      src2 = 5'($urandom_range(0, 7)); src2_valid = 1'($urandom_range(0, 1));
      wb_valid = 1'($urandom_range(0, 1));
      wb_reg_write = ($urandom_range(0, 7) != 0);
      if (pend.size() > 0 && $urandom_range(0, 9) != 0)
        wb_rd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wb_rd = 5'($urandom_range(0, 7));
      wb_mem_to_reg = 1'($urandom_range(0, 1));
      wb_is_LB = 1'($urandom_range(0, 1));
      wb_byte_sel = 2'($urandom_range(0, 3));
      alu_result = $urandom;
      mem_data = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
